// File: rtl/cordic_pkg.sv
// Shared constants and the angle-fold helper for the CORDIC pre-rotation stage.
// The fold maps any legal angle in [-180,+180] into [-90,+90] and reports a half-turn flip.
package cordic_pkg;

   localparam int FOLD_W = 9;

   localparam logic signed [FOLD_W-1:0] ANG_90  = 9'sd90;
   localparam logic signed [FOLD_W-1:0] ANG_180 = 9'sd180;

   typedef struct packed {
      logic                     flip;
      logic signed [FOLD_W-1:0] z;
   } fold_t;

   function automatic fold_t fold_angle(input logic signed [FOLD_W-1:0] angle);
      fold_t r;
      if (angle > ANG_90) begin
         r.flip = 1'b1;
         r.z    = angle - ANG_180;
      end else if (angle < -ANG_90) begin
         r.flip = 1'b1;
         r.z    = angle + ANG_180;
      end else begin
         r.flip = 1'b0;
         r.z    = angle;
      end
      return r;
   endfunction

endpackage

// File: rtl/skid_buffer_2e.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one overflow slot.
// o_ready is registered and drops only when the overflow slot is occupied.
module skid_buffer_2e #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_out_valid;
   logic [W-1:0] r_out_data;
   logic         r_skid_valid;
   logic [W-1:0] r_skid_data;
   logic         r_ready;

   logic         w_in_fire;
   logic         w_out_fire;
   logic         w_out_valid_nxt;
   logic [W-1:0] w_out_data_nxt;
   logic         w_skid_valid_nxt;
   logic [W-1:0] w_skid_data_nxt;

   assign w_in_fire  = i_valid && r_ready;
   assign w_out_fire = r_out_valid && i_ready;

   // Next-state of both slots; a held skid entry always drains before new input is taken.
   always_comb begin
      w_out_valid_nxt  = r_out_valid;
      w_out_data_nxt   = r_out_data;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;
      if (r_skid_valid) begin
         if (w_out_fire) begin
            w_out_data_nxt   = r_skid_data;
            w_skid_valid_nxt = 1'b0;
         end else begin
            w_out_valid_nxt  = r_out_valid;
         end
      end else if (w_in_fire) begin
         if (!r_out_valid || w_out_fire) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = i_data;
         end else begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_data;
         end
      end else if (w_out_fire) begin
         w_out_valid_nxt = 1'b0;
      end else begin
         w_out_valid_nxt = r_out_valid;
      end
   end

   // Slot registers; reset drops everything in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= {W{1'b0}};
         r_skid_valid <= 1'b0;
         r_skid_data  <= {W{1'b0}};
         r_ready      <= 1'b0;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_out_data   <= w_out_data_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_data  <= w_skid_data_nxt;
         r_ready      <= !w_skid_valid_nxt;
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule

// File: rtl/stage_pre_rotation_hs.sv
// Handshaked CORDIC pre-rotation stage: folds the angle into [-90,+90], builds the four
// seed vertices from the +K/-K pair, and delivers tokens through a 2-entry skid buffer.
module stage_pre_rotation_hs
   import cordic_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int COLOR_W = 9,
   parameter int REF_W   = 9,
   parameter int ANGLE_W = 9,
   parameter int CORD_W  = 19,
   parameter int CNT_W   = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic                      i_in_bubble,
   input  logic [COLOR_W-1:0]        i_in_color,
   input  logic [COORD_W-1:0]        i_in_pixel_x,
   input  logic [COORD_W-1:0]        i_in_pixel_y,
   input  logic [REF_W-1:0]          i_in_ref_x,
   input  logic [REF_W-1:0]          i_in_ref_y,
   input  logic                      i_in_form,
   input  logic signed [ANGLE_W-1:0] i_in_angle,
   input  logic signed [CORD_W-1:0]  i_in_cord_pos,
   input  logic signed [CORD_W-1:0]  i_in_cord_neg,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic                      o_out_bubble,
   output logic [COLOR_W-1:0]        o_out_color,
   output logic [COORD_W-1:0]        o_out_pixel_x,
   output logic [COORD_W-1:0]        o_out_pixel_y,
   output logic [REF_W-1:0]          o_out_ref_x,
   output logic [REF_W-1:0]          o_out_ref_y,
   output logic                      o_out_form,
   output logic [CORD_W-1:0]         o_out_v1_x,
   output logic [CORD_W-1:0]         o_out_v1_y,
   output logic [CORD_W-1:0]         o_out_v2_x,
   output logic [CORD_W-1:0]         o_out_v2_y,
   output logic [CORD_W-1:0]         o_out_v3_x,
   output logic [CORD_W-1:0]         o_out_v3_y,
   output logic [CORD_W-1:0]         o_out_v4_x,
   output logic [CORD_W-1:0]         o_out_v4_y,
   output logic [ANGLE_W-1:0]        o_out_z,
   output logic                      o_out_enable_cordic,
   output logic [CNT_W-1:0]          o_tok_count
);

   localparam int TOK_W = 1 + COLOR_W + 2*COORD_W + 2*REF_W + 1 + 8*CORD_W + ANGLE_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fold_t                      w_fold;
   logic signed [ANGLE_W-1:0]  w_z_fold;
   logic signed [CORD_W-1:0]   w_p;
   logic signed [CORD_W-1:0]   w_n;
   logic [CORD_W-1:0]          w_v1_x, w_v1_y, w_v2_x, w_v2_y;
   logic [CORD_W-1:0]          w_v3_x, w_v3_y, w_v4_x, w_v4_y;
   logic [ANGLE_W-1:0]         w_z;
   logic                       w_en;
   logic [TOK_W-1:0]           w_tok_in;
   logic [TOK_W-1:0]           w_tok_out;
   logic [CNT_W-1:0]           r_tok_count;

   assign w_fold   = fold_angle(FOLD_W'(i_in_angle));
   assign w_z_fold = ANGLE_W'(w_fold.z);

   // A flip swaps the roles of +K and -K, which rotates every seed vertex by 180 degrees.
   always_comb begin
      w_p = w_fold.flip ? i_in_cord_neg : i_in_cord_pos;
      w_n = w_fold.flip ? i_in_cord_pos : i_in_cord_neg;
      if (i_in_bubble) begin
         w_v1_x = {CORD_W{1'b0}};
         w_v1_y = {CORD_W{1'b0}};
         w_v2_x = {CORD_W{1'b0}};
         w_v2_y = {CORD_W{1'b0}};
         w_v3_x = {CORD_W{1'b0}};
         w_v3_y = {CORD_W{1'b0}};
         w_v4_x = {CORD_W{1'b0}};
         w_v4_y = {CORD_W{1'b0}};
         w_z    = {ANGLE_W{1'b0}};
         w_en   = 1'b0;
      end else begin
         w_v1_x = w_p;
         w_v1_y = w_p;
         w_v2_x = w_n;
         w_v2_y = w_p;
         w_v3_x = w_n;
         w_v3_y = w_n;
         w_v4_x = i_in_form ? w_n : w_p;
         w_v4_y = w_n;
         w_z    = w_z_fold;
         w_en   = (w_z_fold != {ANGLE_W{1'b0}});
      end
   end

   assign w_tok_in = {i_in_bubble, i_in_color, i_in_pixel_x, i_in_pixel_y,
                      i_in_ref_x, i_in_ref_y, i_in_form,
                      w_v1_x, w_v1_y, w_v2_x, w_v2_y,
                      w_v3_x, w_v3_y, w_v4_x, w_v4_y,
                      w_z, w_en};

   skid_buffer_2e #(
      .W (TOK_W)
   ) u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (i_in_valid),
      .o_ready (o_in_ready),
      .i_data  (w_tok_in),
      .o_valid (o_out_valid),
      .i_ready (i_out_ready),
      .o_data  (w_tok_out)
   );

   assign {o_out_bubble, o_out_color, o_out_pixel_x, o_out_pixel_y,
           o_out_ref_x, o_out_ref_y, o_out_form,
           o_out_v1_x, o_out_v1_y, o_out_v2_x, o_out_v2_y,
           o_out_v3_x, o_out_v3_y, o_out_v4_x, o_out_v4_y,
           o_out_z, o_out_enable_cordic} = w_tok_out;

   // Delivered-token counter, sticks at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tok_count <= {CNT_W{1'b0}};
      end else if (o_out_valid && i_out_ready && (r_tok_count != CNT_MAX)) begin
         r_tok_count <= r_tok_count + CNT_ONE;
      end
   end

   assign o_tok_count = r_tok_count;

endmodule

// File: tb/tb_stage_pre_rotation_hs.sv
// Self-checking bench: directed vector table, hand-written stall/reset/saturation
// sequences, and randomized traffic checked against a queue-based token model.
module tb_stage_pre_rotation_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_bubble, in_form;
   logic [8:0]  in_color, in_ref_x, in_ref_y;
   logic [9:0]  in_pixel_x, in_pixel_y;
   logic signed [8:0]  in_angle;
   logic signed [18:0] in_cord_pos, in_cord_neg;
   logic        out_valid, out_ready, out_bubble, out_form, out_en;
   logic [8:0]  out_color, out_ref_x, out_ref_y, out_z;
   logic [9:0]  out_pixel_x, out_pixel_y;
   logic [18:0] v1x, v1y, v2x, v2y, v3x, v3y, v4x, v4y;
   logic [31:0] tok_count;

   logic        s_in_ready, s_out_valid, s_out_bubble, s_out_form, s_out_en;
   logic [8:0]  s_out_color, s_out_ref_x, s_out_ref_y, s_out_z;
   logic [9:0]  s_out_pixel_x, s_out_pixel_y;
   logic [18:0] s_v1x, s_v1y, s_v2x, s_v2y, s_v3x, s_v3y, s_v4x, s_v4y;
   logic [2:0]  s_tok_count;

   always #5 clk = ~clk;

   stage_pre_rotation_hs dut (
      .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_bubble(in_bubble), .i_in_color(in_color), .i_in_pixel_x(in_pixel_x),
      .i_in_pixel_y(in_pixel_y), .i_in_ref_x(in_ref_x), .i_in_ref_y(in_ref_y),
      .i_in_form(in_form), .i_in_angle(in_angle), .i_in_cord_pos(in_cord_pos),
      .i_in_cord_neg(in_cord_neg), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_bubble(out_bubble), .o_out_color(out_color), .o_out_pixel_x(out_pixel_x),
      .o_out_pixel_y(out_pixel_y), .o_out_ref_x(out_ref_x), .o_out_ref_y(out_ref_y),
      .o_out_form(out_form), .o_out_v1_x(v1x), .o_out_v1_y(v1y), .o_out_v2_x(v2x),
      .o_out_v2_y(v2y), .o_out_v3_x(v3x), .o_out_v3_y(v3y), .o_out_v4_x(v4x),
      .o_out_v4_y(v4y), .o_out_z(out_z), .o_out_enable_cordic(out_en),
      .o_tok_count(tok_count)
   );

   stage_pre_rotation_hs #(.CNT_W(3)) u_sat (
      .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
      .i_in_bubble(in_bubble), .i_in_color(in_color), .i_in_pixel_x(in_pixel_x),
      .i_in_pixel_y(in_pixel_y), .i_in_ref_x(in_ref_x), .i_in_ref_y(in_ref_y),
      .i_in_form(in_form), .i_in_angle(in_angle), .i_in_cord_pos(in_cord_pos),
      .i_in_cord_neg(in_cord_neg), .o_out_valid(s_out_valid), .i_out_ready(out_ready),
      .o_out_bubble(s_out_bubble), .o_out_color(s_out_color), .o_out_pixel_x(s_out_pixel_x),
      .o_out_pixel_y(s_out_pixel_y), .o_out_ref_x(s_out_ref_x), .o_out_ref_y(s_out_ref_y),
      .o_out_form(s_out_form), .o_out_v1_x(s_v1x), .o_out_v1_y(s_v1y), .o_out_v2_x(s_v2x),
      .o_out_v2_y(s_v2y), .o_out_v3_x(s_v3x), .o_out_v3_y(s_v3y), .o_out_v4_x(s_v4x),
      .o_out_v4_y(s_v4y), .o_out_z(s_out_z), .o_out_enable_cordic(s_out_en),
      .o_tok_count(s_tok_count)
   );

   typedef struct {
      int bubble, color, px, py, rx, ry, form;
      int v1x, v1y, v2x, v2y, v3x, v3y, v4x, v4y, z, en;
   } tok_t;

   typedef struct {
      int angle, pos, neg, form, bubble;
      int z, v1x, v1y, v2x, v2y, v3x, v3y, v4x, v4y, en;
   } vec_t;

   tok_t q[$];
   int   dz[$];
   int   m_rdy, m_cnt;
   int   n_checks = 0, n_errors = 0;
   int   s_valid, s_bub, s_ang, s_pos, s_neg, s_form, s_color, s_px, s_py, s_rx, s_ry;
   vec_t tbl[8];

   task automatic chk(string nm, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(int v, int b, int ang, int pos, int neg, int f);
      s_valid = v; s_bub = b; s_ang = ang; s_pos = pos; s_neg = neg; s_form = f;
      s_color = int'($urandom_range(0, 511));
      s_px = int'($urandom_range(0, 1023)); s_py = int'($urandom_range(0, 1023));
      s_rx = int'($urandom_range(0, 511));  s_ry = int'($urandom_range(0, 511));
      in_valid = (v != 0); in_bubble = (b != 0); in_form = (f != 0);
      in_angle = 9'(ang); in_cord_pos = 19'(pos); in_cord_neg = 19'(neg);
      in_color = 9'(s_color); in_pixel_x = 10'(s_px); in_pixel_y = 10'(s_py);
      in_ref_x = 9'(s_rx); in_ref_y = 9'(s_ry);
   endtask

   function automatic tok_t model_tok();
      tok_t t;
      int flip, p, n;
      t.bubble = s_bub; t.color = s_color; t.px = s_px; t.py = s_py;
      t.rx = s_rx; t.ry = s_ry; t.form = s_form;
      t.v1x = 0; t.v1y = 0; t.v2x = 0; t.v2y = 0;
      t.v3x = 0; t.v3y = 0; t.v4x = 0; t.v4y = 0; t.z = 0; t.en = 0;
      if (s_bub == 0) begin
         if (s_ang > 90)       begin t.z = s_ang - 180; flip = 1; end
         else if (s_ang < -90) begin t.z = s_ang + 180; flip = 1; end
         else                  begin t.z = s_ang;       flip = 0; end
         p = flip ? s_neg : s_pos;
         n = flip ? s_pos : s_neg;
         t.v1x = p; t.v1y = p; t.v2x = n; t.v2y = p; t.v3x = n; t.v3y = n;
         t.v4x = (s_form != 0) ? n : p; t.v4y = n;
         t.en = (t.z != 0) ? 1 : 0;
      end
      return t;
   endfunction

   task automatic cmp_tok(tok_t e);
      chk("out_bubble", out_bubble, e.bubble);   chk("out_color", out_color, e.color);
      chk("out_pixel_x", out_pixel_x, e.px);     chk("out_pixel_y", out_pixel_y, e.py);
      chk("out_ref_x", out_ref_x, e.rx);         chk("out_ref_y", out_ref_y, e.ry);
      chk("out_form", out_form, e.form);
      chk("v1_x", $signed(v1x), e.v1x); chk("v1_y", $signed(v1y), e.v1y);
      chk("v2_x", $signed(v2x), e.v2x); chk("v2_y", $signed(v2y), e.v2y);
      chk("v3_x", $signed(v3x), e.v3x); chk("v3_y", $signed(v3y), e.v3y);
      chk("v4_x", $signed(v4x), e.v4x); chk("v4_y", $signed(v4y), e.v4y);
      chk("out_z", $signed(out_z), e.z); chk("enable_cordic", out_en, e.en);
   endtask

   // One clock: check against the model before the edge, then advance the model.
   task automatic step();
      tok_t t;
      int in_f, out_f;
      assert (s_ang >= -180 && s_ang <= 180) else $error("illegal angle %0d driven", s_ang);
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      chk("sat_out_valid", s_out_valid, (q.size() > 0) ? 1 : 0);
      chk("tok_count", tok_count, m_cnt);
      chk("sat_tok_count", s_tok_count, (m_cnt > 7) ? 7 : m_cnt);
      if (q.size() > 0) cmp_tok(q[0]);
      in_f  = (s_valid != 0 && m_rdy != 0) ? 1 : 0;
      out_f = (q.size() > 0 && out_ready) ? 1 : 0;
      t = model_tok();
      if (out_f != 0 && !reset) dz.push_back(int'($signed(out_z)));
      @(posedge clk);
      if (reset) begin
         q.delete(); m_cnt = 0; m_rdy = 0;
      end else begin
         if (out_f != 0) begin void'(q.pop_front()); m_cnt++; end
         if (in_f != 0) q.push_back(t);
         m_rdy = (q.size() < 2) ? 1 : 0;
      end
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{120, 1000, -1000, 0, 0, -60, -1000, -1000, 1000, -1000, 1000, 1000, -1000, 1000, 1};
      tbl[1] = '{-180, 1000, -1000, 0, 0, 0, -1000, -1000, 1000, -1000, 1000, 1000, -1000, 1000, 0};
      tbl[2] = '{-90, 1000, -1000, 0, 0, -90, 1000, 1000, -1000, 1000, -1000, -1000, 1000, -1000, 1};
      tbl[3] = '{0, 1000, -1000, 0, 0, 0, 1000, 1000, -1000, 1000, -1000, -1000, 1000, -1000, 0};
      tbl[4] = '{90, 1000, -1000, 0, 0, 90, 1000, 1000, -1000, 1000, -1000, -1000, 1000, -1000, 1};
      tbl[5] = '{180, 1000, -1000, 0, 0, 0, -1000, -1000, 1000, -1000, 1000, 1000, -1000, 1000, 0};
      tbl[6] = '{30, 500, -500, 1, 0, 30, 500, 500, -500, 500, -500, -500, -500, -500, 1};
      tbl[7] = '{45, 700, -700, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      reset = 1'b1; out_ready = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      q.delete(); m_rdy = 0; m_cnt = 0;
      chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
      chk("rst_tok_count", tok_count, 0); chk("rst_z", out_z, 0);
      chk("rst_v1_x", v1x, 0);            chk("rst_enable", out_en, 0);
      chk("rst_color", out_color, 0);
      reset = 1'b0;
      step();

      // Directed vector table, back-to-back at full throughput.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(1, tbl[i].bubble, tbl[i].angle, tbl[i].pos, tbl[i].neg, tbl[i].form);
         step();
         chk("tbl_valid", out_valid, 1);
         chk("tbl_z", $signed(out_z), tbl[i].z);
         chk("tbl_v1_x", $signed(v1x), tbl[i].v1x); chk("tbl_v1_y", $signed(v1y), tbl[i].v1y);
         chk("tbl_v2_x", $signed(v2x), tbl[i].v2x); chk("tbl_v2_y", $signed(v2y), tbl[i].v2y);
         chk("tbl_v3_x", $signed(v3x), tbl[i].v3x); chk("tbl_v3_y", $signed(v3y), tbl[i].v3y);
         chk("tbl_v4_x", $signed(v4x), tbl[i].v4x); chk("tbl_v4_y", $signed(v4y), tbl[i].v4y);
         chk("tbl_enable", out_en, tbl[i].en);
         chk("tbl_bubble", out_bubble, tbl[i].bubble);
      end
      set_in(0, 0, 0, 0, 0, 0);
      step();
      chk("tbl_count", tok_count, 8);

      // Stall: A held, B in skid, C refused; then release and check order.
      out_ready = 1'b0;
      set_in(1, 0, 10, 777, -777, 0); step();
      set_in(1, 0, 20, 777, -777, 0); step();
      set_in(1, 0, 30, 777, -777, 0); step();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_held_z", $signed(out_z), 10);
      dz.delete();
      out_ready = 1'b1;
      step(); step();
      set_in(0, 0, 0, 0, 0, 0);
      step(); step();
      chk("order_len", dz.size(), 3);
      if (dz.size() == 3) begin
         chk("order_0", dz[0], 10); chk("order_1", dz[1], 20); chk("order_2", dz[2], 30);
      end

      // Reset with output register and skid both occupied.
      out_ready = 1'b0;
      set_in(1, 0, 60, 300, -300, 0); step();
      set_in(1, 0, -60, 300, -300, 0); step();
      reset = 1'b1; set_in(0, 0, 0, 0, 0, 0); step();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", tok_count, 0);
      chk("mid_rst_ready", in_ready, 0);
      reset = 1'b0; step();
      chk("post_rst_ready", in_ready, 1);

      // Counter saturation on the 3-bit instance.
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         set_in(1, 0, 5 * i, 100, -100, 0);
         step();
      end
      set_in(0, 0, 0, 0, 0, 0); step();
      chk("sat_hold", s_tok_count, 7);
      chk("nosat_count", tok_count, 9);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         begin
            int pos;
            pos = int'($urandom_range(0, 262143));
            set_in(($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
                   int'($urandom_range(0, 360)) - 180, pos, -pos, int'($urandom_range(0, 1)));
         end
         step();
      end
      reset = 1'b0; out_ready = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
